// File: rtl/deserializer_rx.sv
// rtl/deserializer_rx.sv - oversampled UART-style frame receiver with parity and stop checking
//
// Purpose: decodes frames of 1 start bit (0), DATA_WIDTH data bits LSB first,
// an optional parity bit and 1 stop bit (1) from an oversampled serial line.
// Each bit is the majority vote of three samples around the bit centre.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   RX_IN      - serial line, idles high, already synchronous to clk
//   Prescale   - clocks per bit: 8, 16 or 32 (anything else behaves as 8)
//   PAR_EN     - 1: a parity bit follows the data
//   PAR_TYP    - 0: even parity, 1: odd parity
//   P_Data     - last error-free payload, held between frames
//   Data_Valid - 1-cycle pulse when P_Data is loaded
//   Par_Err    - 1-cycle pulse for a frame with a parity mismatch
//   Stp_Err    - 1-cycle pulse for a frame whose stop bit was 0
module deserializer_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [2:0]            state;
  logic [5:0]            presc;
  logic [5:0]            edge_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  samp0;
  logic                  samp1;
  logic                  bit_val;
  logic                  frame_done;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic [5:0] presc_sel;
  logic [5:0] half;
  logic [5:0] last;
  logic       end_of_bit;

  always_comb begin
    presc_sel = 6'd8;
    if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32) begin
      presc_sel = Prescale;
    end
  end

  assign half       = presc >> 1;
  assign last       = presc - 6'd1;
  assign end_of_bit = (edge_cnt == last);

  // Three samples around the bit centre; the vote is resolved on the third
  // sample so bit_val is stable well before the end-of-bit clock uses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp0   <= 1'b1;
      samp1   <= 1'b1;
      bit_val <= 1'b1;
    end else if (state != IDLE) begin
      if (edge_cnt == half - 6'd1) begin
        samp0 <= RX_IN;
      end
      if (edge_cnt == half) begin
        samp1 <= RX_IN;
      end
      if (edge_cnt == half + 6'd1) begin
        bit_val <= (samp0 & samp1) | (samp0 & RX_IN) | (samp1 & RX_IN);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= 6'd8;
      edge_cnt   <= 6'd0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      frame_done <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      P_Data     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      frame_done <= 1'b0;

      // Result of the frame that ended on the previous clock; runs in
      // parallel with a possible new start so back-to-back frames work.
      if (frame_done) begin
        if (par_err_q || stp_err_q) begin
          Par_Err <= par_err_q;
          Stp_Err <= stp_err_q;
        end else begin
          Data_Valid <= 1'b1;
          P_Data     <= shift_reg;
        end
      end

      if (state == IDLE) begin
        edge_cnt <= 6'd0;
      end else if (end_of_bit) begin
        edge_cnt <= 6'd0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            // This clock is edge count 0 of the start bit.
            state     <= START;
            edge_cnt  <= 6'd1;
            presc     <= presc_sel;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        START: begin
          if (end_of_bit) begin
            state <= bit_val ? IDLE : DATA;
          end
        end
        DATA: begin
          if (end_of_bit) begin
            shift_reg[bit_cnt] <= bit_val;
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (end_of_bit) begin
            par_err_q <= (bit_val != ((^shift_reg) ^ par_typ_q));
            state     <= STOP;
          end
        end
        STOP: begin
          if (end_of_bit) begin
            stp_err_q  <= ~bit_val;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_rx.sv
// tb/tb_deserializer_rx.sv - self-checking bench for deserializer_rx
module tb_deserializer_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  always #5 clk = ~clk;

  deserializer_rx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } pulse_t;

  pulse_t obs[$];
  pulse_t exp_q[$];

  always @(negedge clk) begin
    if (Data_Valid || Par_Err || Stp_Err) begin
      obs.push_back('{cyc, Data_Valid, Par_Err, Stp_Err, P_Data});
    end
  end

  typedef struct {
    logic [7:0] d;
    int         presc;
    bit         pen;
    bit         ptyp;
    bit         pbit;
    bit         stop;
    int         lat;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one frame; each bit is held for the effective prescale. Returns
  // c0, the cycle stamp of the start-edge clock as seen by the monitor.
  task automatic send_frame(input logic [7:0] d, input int presc_in, input bit pen,
                            input bit ptyp, input bit pbit, input bit stop,
                            input bit scramble, input int abort_at, output int c0);
    int eff;
    int n;
    bit bits[$];
    eff = (presc_in == 8 || presc_in == 16 || presc_in == 32) ? presc_in : 8;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stop);
    n  = 0;
    c0 = 0;
    foreach (bits[b]) begin
      repeat (eff) begin
        if (abort_at >= 0 && n == abort_at) return;
        @(negedge clk);
        if (n == 0) begin
          Prescale = presc_in[5:0];
          PAR_EN   = pen;
          PAR_TYP  = ptyp;
          c0       = cyc + 1;
        end else if (scramble) begin
          Prescale = 6'($urandom_range(0, 63));
          PAR_EN   = 1'($urandom_range(0, 1));
          PAR_TYP  = 1'($urandom_range(0, 1));
        end
        RX_IN = bits[b];
        n++;
      end
    end
  endtask

  task automatic drain(input int n);
    pulse_t e;
    pulse_t o;
    repeat (n) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_pulse: got none expected pulse at cycle %0d", e.cyc);
      end else begin
        o = obs.pop_front();
        check("pulse_cycle", o.cyc, e.cyc);
        check("data_valid", {31'd0, o.dv}, {31'd0, e.dv});
        check("par_err", {31'd0, o.pe}, {31'd0, e.pe});
        check("stp_err", {31'd0, o.se}, {31'd0, e.se});
        check("p_data", {24'd0, o.data}, {24'd0, e.data});
      end
    end
    check("extra_pulses", obs.size(), 0);
    obs.delete();
  endtask

  logic [7:0] last_good;
  int         c0;
  int         c0b;

  initial begin
    //       d      presc pen ptyp pbit stop lat  dv pe se data
    vt[0] = '{8'hA5, 8,  0, 0, 0, 1, 80,  1, 0, 0, 8'hA5};
    vt[1] = '{8'h3C, 16, 1, 0, 0, 1, 176, 1, 0, 0, 8'h3C};
    vt[2] = '{8'h3C, 16, 1, 0, 1, 1, 176, 0, 1, 0, 8'h3C};
    vt[3] = '{8'h81, 8,  0, 0, 0, 0, 80,  0, 0, 1, 8'h3C};
    vt[4] = '{8'h81, 8,  1, 1, 0, 0, 88,  0, 1, 1, 8'h3C};
    vt[5] = '{8'h6B, 12, 1, 1, 0, 1, 88,  1, 0, 0, 8'h6B};
    vt[6] = '{8'h00, 32, 1, 1, 1, 1, 352, 1, 0, 0, 8'h00};

    rst      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_p_data", {24'd0, P_Data}, 32'd0);
    check("reset_data_valid", {31'd0, Data_Valid}, 32'd0);
    check("reset_par_err", {31'd0, Par_Err}, 32'd0);
    check("reset_stp_err", {31'd0, Stp_Err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table; config inputs are scrambled mid-frame.
    foreach (vt[i]) begin
      send_frame(vt[i].d, vt[i].presc, vt[i].pen, vt[i].ptyp, vt[i].pbit, vt[i].stop, 1'b1, -1, c0);
      exp_q.push_back('{c0 + vt[i].lat, vt[i].dv, vt[i].pe, vt[i].se, vt[i].data});
      drain(4);
    end

    // Start glitch: 3 low clocks at prescale 16, then a valid frame.
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      RX_IN = 1'b0;
    end
    drain(40);
    send_frame(8'h5A, 16, 0, 0, 0, 1, 0, -1, c0);
    exp_q.push_back('{c0 + 160, 1'b1, 1'b0, 1'b0, 8'h5A});
    drain(4);

    // Back-to-back at prescale 32 with no idle gap.
    send_frame(8'h55, 32, 0, 0, 0, 1, 0, -1, c0);
    send_frame(8'hAA, 32, 0, 0, 0, 1, 0, -1, c0b);
    exp_q.push_back('{c0 + 320, 1'b1, 1'b0, 1'b0, 8'h55});
    exp_q.push_back('{c0b + 320, 1'b1, 1'b0, 1'b0, 8'hAA});
    drain(4);

    // Reset during data bit 4.
    send_frame(8'h99, 8, 0, 0, 0, 1, 0, 5 * 8 + 3, c0);
    @(negedge clk);
    rst   = 1'b0;
    RX_IN = 1'b1;
    @(negedge clk);
    check("midrst_p_data", {24'd0, P_Data}, 32'd0);
    check("midrst_data_valid", {31'd0, Data_Valid}, 32'd0);
    check("midrst_par_err", {31'd0, Par_Err}, 32'd0);
    check("midrst_stp_err", {31'd0, Stp_Err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drain(100);
    send_frame(8'hF0, 8, 0, 0, 0, 1, 0, -1, c0);
    exp_q.push_back('{c0 + 80, 1'b1, 1'b0, 1'b0, 8'hF0});
    drain(4);
    last_good = 8'hF0;

    // Randomised frames against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int         presc_in;
      int         eff;
      bit         pen;
      bit         ptyp;
      bit         pbit;
      bit         stop;
      int         ones;
      bit         perr;
      bit         serr;
      int         lat;
      int         plist[6] = '{8, 16, 32, 8, 5, 20};
      d        = 8'($urandom);
      presc_in = plist[$urandom_range(0, 5)];
      pen      = 1'($urandom_range(0, 1));
      ptyp     = 1'($urandom_range(0, 1));
      pbit     = 1'($urandom_range(0, 1));
      stop     = ($urandom_range(0, 3) != 0);
      send_frame(d, presc_in, pen, ptyp, pbit, stop, 1'b1, -1, c0);

      eff  = (presc_in == 8 || presc_in == 16 || presc_in == 32) ? presc_in : 8;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (d[i] ? 1 : 0);
      perr = pen && (pbit != ((ones % 2 == 1) ^ ptyp));
      serr = !stop;
      lat  = (1 + 8 + (pen ? 1 : 0) + 1) * eff;
      if (perr || serr) begin
        exp_q.push_back('{c0 + lat, 1'b0, perr, serr, last_good});
      end else begin
        exp_q.push_back('{c0 + lat, 1'b1, 1'b0, 1'b0, d});
        last_good = d;
      end
      if ($urandom_range(0, 2) != 0 || k == 23) drain(4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializer_rx.md
DESERIALIZER_RX -- requirements
Module: deserializer_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port RX_IN, input, 1, serial line; idles high; already synchronous to clk.
REQ-005 SHALL have port Prescale, input, 6, oversampling ratio in clocks per bit: 8, 16 or 32.
REQ-006 SHALL have port PAR_EN, input, 1; 1 means a parity bit follows the data.
REQ-007 SHALL have port PAR_TYP, input, 1; 0 means even parity, 1 means odd.
REQ-008 SHALL have port P_Data, output, DATA_WIDTH, registered received payload.
REQ-009 SHALL have port Data_Valid, output, 1, registered 1-cycle pulse when P_Data updates.
REQ-010 SHALL have port Par_Err, output, 1, registered 1-cycle parity-error pulse.
REQ-011 SHALL have port Stp_Err, output, 1, registered 1-cycle stop-error pulse.

Function
REQ-012 SHALL decode frames as 1 start bit (0), then DATA_WIDTH data bits LSB first, then a parity bit if PAR_EN, then 1 stop bit (1).
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE, the first clock with RX_IN==0 SHALL be edge count 0 of the start bit, SHALL move the FSM to START, and SHALL latch Prescale, PAR_EN and PAR_TYP for the frame.
REQ-015 Changes on Prescale, PAR_EN and PAR_TYP mid-frame SHALL be ignored; a latched Prescale not in {8,16,32} SHALL be treated as 8.
REQ-016 An edge counter SHALL count 0..Prescale-1 within each bit and wrap to 0; a bit counter SHALL index the data bits 0..DATA_WIDTH-1.
REQ-017 Each bit value SHALL be the majority vote of RX_IN sampled at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-018 State transitions SHALL occur on the clock where the edge count equals Prescale-1 (end of bit).
REQ-019 If the voted start bit is 1 (glitch), the FSM SHALL return to IDLE with no output pulse and P_Data unchanged.
REQ-020 The DATA state SHALL shift each voted bit into an internal shift register at bit index order, LSB first.
REQ-021 After the last data bit, the FSM SHALL go to PARITY if PAR_EN, else to STOP.
REQ-022 The PARITY state SHALL compare the voted parity bit against the XOR of the data (even) or its inverse (odd), and SHALL record a mismatch for the frame.
REQ-023 The STOP state SHALL record a stop error if the voted stop bit is 0.
REQ-024 At the end of the stop bit, the FSM SHALL return to IDLE, and on the next clock SHALL issue exactly one of:
  - Data_Valid=1 with P_Data loaded, when there is no error;
  - Par_Err=1 and/or Stp_Err=1, with P_Data unchanged.
REQ-025 Latency from the start-edge clock to the Data_Valid pulse SHALL be (2+DATA_WIDTH+PAR_EN)*Prescale clocks.
REQ-026 Back-to-back frames SHALL be accepted: a 0 on RX_IN in the clock after the return to IDLE starts a new frame.
REQ-027 Output pulses SHALL last exactly one clock, and P_Data SHALL hold its value between valid frames.

Reset
REQ-028 While rst=0, the block SHALL enter IDLE and clear the counters and shift register, with P_Data=0, Data_Valid=0, Par_Err=0 and Stp_Err=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the next falling edge on RX_IN begins a fresh frame.

Verification
REQ-030 Prescale=8, PAR_EN=0, send 0xA5 -> P_Data=0xA5; Data_Valid high for exactly 1 clock, 80 clocks after the start edge.
REQ-031 Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> Data_Valid with 0x3C; resend with parity 1 -> Par_Err pulse, no Data_Valid, P_Data still 0x3C.
REQ-032 Prescale=8, send 0x81 with stop bit 0 -> Stp_Err pulse, no Data_Valid.
REQ-033 Prescale=16, RX_IN low for 3 clocks then high -> no pulse, FSM back in IDLE; a following valid frame with 0x5A -> Data_Valid, P_Data=0x5A.
REQ-034 Prescale=32, back-to-back 0x55 then 0xAA with no idle gap -> two Data_Valid pulses 320 clocks apart with the correct bytes.
REQ-035 Assert rst during data bit 4 of a frame -> all outputs 0, no pulse; after release, a frame with 0xF0 -> Data_Valid, P_Data=0xF0.
